// File: rtl/matvec_sequencer_if.sv
// Launch/config inputs plus buffer-instruction and PE-strobe outputs of the
// tiled matrix-vector sequencer.
interface matvec_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MODE_W = 2,
  parameter int unsigned CNT_W  = 8
);
  // launch request and operation config
  logic              start;
  logic [CNT_W-1:0]  num_rows;
  logic [CNT_W-1:0]  num_k;
  logic [ADDR_W-1:0] mat_base;
  logic [ADDR_W-1:0] vec_base;
  logic [ADDR_W-1:0] out_base;
  logic [MODE_W-1:0] mode;

  // buffer instruction port
  logic              buf_inst_valid;
  logic [1:0]        buf_opcode;
  logic [ADDR_W-1:0] buf_mema_offset;
  logic [ADDR_W-1:0] buf_memb_offset;
  logic [MODE_W-1:0] buf_mode;

  // PE strobes and status
  logic              pe_data_valid;
  logic              pe_first;
  logic              pe_last;
  logic              busy;
  logic              done;

  // launcher side: issues start/config, observes the sequencer
  modport master (
    output start, num_rows, num_k, mat_base, vec_base, out_base, mode,
    input  buf_inst_valid, buf_opcode, buf_mema_offset, buf_memb_offset, buf_mode,
    input  pe_data_valid, pe_first, pe_last, busy, done
  );

  // sequencer side
  modport slave (
    input  start, num_rows, num_k, mat_base, vec_base, out_base, mode,
    output buf_inst_valid, buf_opcode, buf_mema_offset, buf_memb_offset, buf_mode,
    output pe_data_valid, pe_first, pe_last, busy, done
  );
endinterface

// File: rtl/matvec_sequencer.sv
// Sequencer for a tiled matrix-vector op: K buffer reads per row, PE strobes
// aligned to the 2-cycle read latency, then one result write per row.
module matvec_sequencer #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned MODE_W   = 2,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PE_LAT   = 2,
  parameter logic [1:0]  OP_NOP   = 2'd0,
  parameter logic [1:0]  OP_READ  = 2'd1,
  parameter logic [1:0]  OP_WRITE = 2'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  matvec_sequencer_if.slave   bus
);

  localparam int unsigned DRN_W = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  k_cnt;
  logic [CNT_W-1:0]  num_rows_q;
  logic [CNT_W-1:0]  num_k_q;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] vec_base_q;
  logic [ADDR_W-1:0] out_base_q;
  logic [DRN_W-1:0]  drain_cnt;

  // first stage of the read-data alignment pipe
  logic              p1_valid;
  logic              p1_first;
  logic              p1_last;

  logic              last_k;
  logic              last_r;
  logic [CNT_W-1:0]  k_nxt;

  assign last_k = (k_cnt == num_k_q - CNT_W'(1));
  assign last_r = (r_cnt == num_rows_q - CNT_W'(1));
  assign k_nxt  = k_cnt + CNT_W'(1);

  // Outputs are registered: each transition loads the values for the cycle
  // of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= S_IDLE;
      r_cnt               <= '0;
      k_cnt               <= '0;
      num_rows_q          <= '0;
      num_k_q             <= '0;
      row_base            <= '0;
      vec_base_q          <= '0;
      out_base_q          <= '0;
      drain_cnt           <= '0;
      p1_valid            <= 1'b0;
      p1_first            <= 1'b0;
      p1_last             <= 1'b0;
      bus.buf_inst_valid  <= 1'b0;
      bus.buf_opcode      <= OP_NOP;
      bus.buf_mema_offset <= '0;
      bus.buf_memb_offset <= '0;
      bus.buf_mode        <= '0;
      bus.pe_data_valid   <= 1'b0;
      bus.pe_first        <= 1'b0;
      bus.pe_last         <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
    end else begin
      // a read issued now surfaces as PE data two cycles later
      p1_valid          <= (state == S_READ);
      p1_first          <= (state == S_READ) && (k_cnt == '0);
      p1_last           <= (state == S_READ) && last_k;
      bus.pe_data_valid <= p1_valid;
      bus.pe_first      <= p1_first;
      bus.pe_last       <= p1_last;

      bus.buf_inst_valid  <= 1'b0;
      bus.buf_opcode      <= OP_NOP;
      bus.buf_mema_offset <= '0;
      bus.buf_memb_offset <= '0;
      bus.done            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            num_rows_q   <= bus.num_rows;
            num_k_q      <= bus.num_k;
            row_base     <= bus.mat_base;
            vec_base_q   <= bus.vec_base;
            out_base_q   <= bus.out_base;
            bus.buf_mode <= bus.mode;
            r_cnt        <= '0;
            k_cnt        <= '0;
            if ((bus.num_rows == '0) || (bus.num_k == '0)) begin
              state <= S_FIN;
            end else begin
              state               <= S_READ;
              bus.busy            <= 1'b1;
              bus.buf_inst_valid  <= 1'b1;
              bus.buf_opcode      <= OP_READ;
              bus.buf_mema_offset <= bus.mat_base;
              bus.buf_memb_offset <= bus.vec_base;
            end
          end
        end

        S_READ: begin
          if (last_k) begin
            state     <= S_DRAIN;
            drain_cnt <= DRN_W'(PE_LAT);
          end else begin
            k_cnt               <= k_nxt;
            bus.buf_inst_valid  <= 1'b1;
            bus.buf_opcode      <= OP_READ;
            bus.buf_mema_offset <= row_base + ADDR_W'(k_nxt);
            bus.buf_memb_offset <= vec_base_q + ADDR_W'(k_nxt);
          end
        end

        // PE_LAT+1 idle cycles so the write lands PE_LAT after the last beat
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            state               <= S_WRITE;
            bus.buf_inst_valid  <= 1'b1;
            bus.buf_opcode      <= OP_WRITE;
            bus.buf_mema_offset <= out_base_q + ADDR_W'(r_cnt);
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end

        S_WRITE: begin
          row_base <= row_base + ADDR_W'(num_k_q);
          k_cnt    <= '0;
          if (last_r) begin
            state    <= S_FIN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state               <= S_READ;
            r_cnt               <= r_cnt + CNT_W'(1);
            bus.buf_inst_valid  <= 1'b1;
            bus.buf_opcode      <= OP_READ;
            bus.buf_mema_offset <= row_base + ADDR_W'(num_k_q);
            bus.buf_memb_offset <= vec_base_q;
          end
        end

        // An empty launch enters here with done low and pulses it one cycle later.
        S_FIN: begin
          if (bus.done) begin
            state <= S_IDLE;
          end else begin
            bus.done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Randomized scoreboard bench for matvec_sequencer: a row/tile reference model
// queues timed expected events, a negedge monitor pops and compares them.
module tb_matvec_sequencer;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PE_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matvec_sequencer_if #(.ADDR_W(ADDR_W), .MODE_W(MODE_W), .CNT_W(CNT_W)) bus ();

  matvec_sequencer #(
    .ADDR_W(ADDR_W), .MODE_W(MODE_W), .CNT_W(CNT_W), .PE_LAT(PE_LAT),
    .OP_NOP(2'd0), .OP_READ(2'd1), .OP_WRITE(2'd2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  md;
    logic        f;
    logic        l;
  } ev_t;

  ev_t inst_q[$];
  ev_t pe_q[$];
  int  done_q[$];

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int busy_from = 1;
  int busy_to = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s cyc=%0d", name, cyc);
  endtask

  function automatic ev_t mk(input int c, input logic [1:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [1:0] md,
                             input logic f, input logic l);
    ev_t e;
    e.cyc = c; e.op = op; e.a = a; e.b = b; e.md = md; e.f = f; e.l = l;
    return e;
  endfunction

  // Monitor: every event the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    while (inst_q.size() > 0 && inst_q[0].cyc < cyc) begin
      e = inst_q.pop_front();
      flag($sformatf("inst_missing exp_cyc=%0d op=%0d a=%0h", e.cyc, e.op, e.a));
    end
    while (pe_q.size() > 0 && pe_q[0].cyc < cyc) begin
      e = pe_q.pop_front();
      flag($sformatf("pe_missing exp_cyc=%0d", e.cyc));
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      flag($sformatf("done_missing exp_cyc=%0d", done_q[0]));
      void'(done_q.pop_front());
    end

    if (bus.buf_inst_valid) begin
      if (inst_q.size() == 0 || inst_q[0].cyc != cyc) begin
        flag($sformatf("inst_unexpected op=%0d a=%0h", bus.buf_opcode, bus.buf_mema_offset));
      end else begin
        e = inst_q.pop_front();
        chk("opcode", 32'(bus.buf_opcode), 32'(e.op));
        chk("mema", 32'(bus.buf_mema_offset), 32'(e.a));
        chk("memb", 32'(bus.buf_memb_offset), 32'(e.b));
        if (e.op == 2'd1) chk("mode", 32'(bus.buf_mode), 32'(e.md));
      end
    end else begin
      chk("idle_opcode", 32'(bus.buf_opcode), 32'(0));
    end

    if (bus.pe_data_valid) begin
      if (pe_q.size() == 0 || pe_q[0].cyc != cyc) begin
        flag("pe_unexpected");
      end else begin
        e = pe_q.pop_front();
        chk("pe_first", 32'(bus.pe_first), 32'(e.f));
        chk("pe_last", 32'(bus.pe_last), 32'(e.l));
      end
    end

    if (bus.done) begin
      if (done_q.size() == 0 || done_q[0] != cyc) begin
        flag("done_unexpected");
      end else begin
        void'(done_q.pop_front());
        chk("done_busy", 32'(bus.busy), 32'(0));
      end
    end

    chk("busy", 32'(bus.busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
  end

  task automatic randomize_cfg();
    bus.num_rows = 8'($urandom);
    bus.num_k    = 8'($urandom);
    bus.mat_base = 16'($urandom);
    bus.vec_base = 16'($urandom);
    bus.out_base = 16'($urandom);
    bus.mode     = 2'($urandom);
  endtask

  // Launch at a negedge; reference model pushes the full timed event list.
  task automatic launch(input int R, input int K, input logic [15:0] mb,
                        input logic [15:0] vb, input logic [15:0] ob,
                        input logic [1:0] md, output int s, output int done_c);
    int rl;
    int t0;
    @(negedge clk);
    bus.num_rows = 8'(R);
    bus.num_k    = 8'(K);
    bus.mat_base = mb;
    bus.vec_base = vb;
    bus.out_base = ob;
    bus.mode     = md;
    bus.start    = 1'b1;
    s  = cyc;
    rl = K + int'(PE_LAT) + 2;
    if (R == 0 || K == 0) begin
      done_c = s + 2;
    end else begin
      for (int r = 0; r < R; r++) begin
        t0 = s + 1 + r * rl;
        for (int k = 0; k < K; k++) begin
          inst_q.push_back(mk(t0 + k, 2'd1, mb + 16'(r * K + k), vb + 16'(k), md, 1'b0, 1'b0));
          pe_q.push_back(mk(t0 + k + 2, 2'd0, 16'd0, 16'd0, 2'd0, k == 0, k == K - 1));
        end
        inst_q.push_back(mk(t0 + K + 1 + int'(PE_LAT), 2'd2, ob + 16'(r), 16'd0, md, 1'b0, 1'b0));
      end
      done_c    = s + 1 + R * rl;
      busy_from = s + 1;
      busy_to   = done_c - 1;
    end
    done_q.push_back(done_c);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input int R, input int K, input logic [15:0] mb,
                        input logic [15:0] vb, input logic [15:0] ob,
                        input logic [1:0] md, input bit noisy);
    int s;
    int done_c;
    launch(R, K, mb, vb, ob, md, s, done_c);
    while (cyc < done_c + 2) begin
      if (noisy && cyc < done_c) begin
        bus.start = 1'($urandom);
        randomize_cfg();
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.buf_inst_valid), 32'(0));
    chk({tag, "_opcode"}, 32'(bus.buf_opcode), 32'(0));
    chk({tag, "_mema"}, 32'(bus.buf_mema_offset), 32'(0));
    chk({tag, "_memb"}, 32'(bus.buf_memb_offset), 32'(0));
    chk({tag, "_mode"}, 32'(bus.buf_mode), 32'(0));
    chk({tag, "_pe_valid"}, 32'(bus.pe_data_valid), 32'(0));
    chk({tag, "_pe_first"}, 32'(bus.pe_first), 32'(0));
    chk({tag, "_pe_last"}, 32'(bus.pe_last), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_done"}, 32'(bus.done), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    int done_c;
    bus.start = 1'($urandom);
    randomize_cfg();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    run_op(1, 1, 16'h0010, 16'h0020, 16'h0030, 2'd1, 1'b0);
    run_op(2, 3, 16'h0100, 16'h0000, 16'h0200, 2'd2, 1'b0);
    run_op(0, 3, 16'h1234, 16'h0000, 16'h0200, 2'd0, 1'b0);
    run_op(2, 0, 16'h1234, 16'h0000, 16'h0200, 2'd0, 1'b0);
    run_op(0, 0, 16'h1234, 16'h0000, 16'h0200, 2'd0, 1'b0);
    run_op(2, 3, 16'h0500, 16'h0040, 16'h0600, 2'd3, 1'b1);
    run_op(2, 4, 16'hFFFE, 16'hFFFD, 16'hFFFF, 2'd1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(1, 4)), int'($urandom_range(1, 6)),
             16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), i[0]);
    end

    // reset during the reads of row 1: everything in flight must vanish
    launch(3, 4, 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), s, done_c);
    while (cyc < s + 10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    inst_q.delete();
    pe_q.delete();
    done_q.delete();
    busy_from = 1;
    busy_to   = 0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    chk("queues_drained", 32'(inst_q.size() + pe_q.size() + done_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matvec_sequencer.md
Name: matvec_sequencer

Overview:
- Upstream control stage that drives the buffer instruction port for a tiled matrix-vector operation.
- For each output row it issues K buffer reads: matrix word plus vector tile.
- It generates PE-side valid, first and last strobes aligned to the buffer's 2-cycle read-data latency.
- After PE drain, it issues one buffer write that stores the PE result to the output memory.

Parameters:
ADDR_W, 16, width of mema/memb offsets and base addresses
MODE_W, 2, width of buffer mode field
CNT_W, 8, width of row/tile counters
PE_LAT, 2, cycles from pe_data_valid of last beat to result valid on output_data (>=1)
OP_NOP, 0, opcode value for no-op
OP_READ, 1, buffer read opcode
OP_WRITE, 2, buffer write opcode

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch request; accepted only in IDLE
num_rows  in  CNT_W  R, output rows to compute
num_k  in  CNT_W  K, tiles accumulated per row
mat_base  in  ADDR_W  matrix word base address
vec_base  in  ADDR_W  vector tile base address
out_base  in  ADDR_W  output word base address
mode  in  MODE_W  vector decode mode, forwarded on reads
buf_inst_valid  out  1  instruction valid
buf_opcode  out  2  OP_READ / OP_WRITE / OP_NOP
buf_mema_offset  out  ADDR_W  matrix address (read) or output address (write)
buf_memb_offset  out  ADDR_W  vector address (read); 0 on write
buf_mode  out  MODE_W  captured mode
pe_data_valid  out  1  matrix_data/vector_data valid this cycle
pe_first  out  1  qualifies first beat of a row (PE clears accumulator)
pe_last  out  1  qualifies last beat of a row
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, buf_opcode=OP_NOP, all counters and delay pipes cleared. This applies mid-operation too; no further instruction or PE strobe appears after reset deasserts until a new start.
- FSM states: IDLE, READ, DRAIN, WRITE, FIN.
- IDLE:
  - On start=1, capture all config inputs into registers and set busy=1 next cycle.
  - If R==0 or K==0, go to FIN.
  - Otherwise go to READ with r=0, k=0, row_base=mat_base.
- READ: one read per cycle, buf_inst_valid=1, opcode OP_READ.
  - mema = row_base + k; memb = vec_base + k; buf_mode = captured mode.
  - When k==K-1, go to DRAIN with drain counter = PE_LAT; otherwise k++.
- Read-data alignment: a read issued in cycle t gives pe_data_valid=1 in cycle t+2. pe_first (k==0) and pe_last (k==K-1) travel in the same 2-stage pipe.
- DRAIN: buf_inst_valid=0, opcode OP_NOP. Lasts PE_LAT+1 cycles, then goes to WRITE.
- WRITE: lasts exactly 1 cycle.
  - buf_inst_valid=1, opcode OP_WRITE, mema = out_base + r, memb=0.
  - If the last read was issued in cycle T, the write is in cycle T+2+PE_LAT.
  - Then row_base += K, k=0.
  - If r==R-1, go to FIN; else r++ and go to READ next cycle.
- FIN: done=1 and busy=0 for one cycle, then go to IDLE.
- busy=1 in READ, DRAIN and WRITE.
- Arithmetic:
  - All address sums are modulo 2^ADDR_W (wrap, no saturation).
  - row_base is a running accumulator; no multiplier.
  - Counters compare against captured R and K, never live inputs.
- start while not IDLE: ignored; config changes during an operation have no effect.
- Rows never overlap: the next row's first read follows its WRITE cycle.

Test Plan:
- Reset values: assert rst_n=0 with random inputs -> all outputs 0 and opcode OP_NOP. Deassert with start=0 for 10 cycles -> no activity.
- R=1, K=1, PE_LAT=2, mat_base=0x10, vec_base=0x20, out_base=0x30, start at cycle 0:
  - Cycle 1: read mema=0x10, memb=0x20.
  - Cycle 3: pe_data_valid=pe_first=pe_last=1.
  - Cycle 5: write mema=0x30.
  - Cycle 6: done=1.
- R=2, K=3, mat_base=0x100, vec_base=0, out_base=0x200:
  - mema reads 0x100,0x101,0x102, then write 0x200.
  - Then reads 0x103,0x104,0x105, then write 0x201.
  - memb sequence 0,1,2 per row; pe_first/pe_last on beats 0 and 2 of each row.
- num_rows=0 (also num_k=0): start -> no buf_inst_valid. done pulses 2 cycles after start; busy stays 0.
- start re-asserted with different config during READ and DRAIN -> ignored; original address sequence completes unchanged.
- mat_base=0xFFFE, K=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-operation: rst_n pulsed low during READ of row 1 -> outputs 0 immediately. In-flight pe_data_valid is squashed; no write issued.
